int_vector_sched: RTL
=====================

# int_vector_sched

Interrupt vectoring scheduler between the interrupt controller and the host CPU bus. It arbitrates among the 16 masked pending interrupt lines and presents one winning source as a vector. The CPU claims that vector with a bus read and closes it with an end-of-interrupt (EOI) write. On EOI the block issues a one-cycle clear pulse to that source and then rescans.

## Interface
Parameters:
- none; width fixed at 16 sources, 4-bit vector.

Ports:
- Clk  input  1  system clock.
- Reset  input  1  synchronous, active-high.
- Addr  input  4  CPU register address, asynchronous to Clk.
- DataRd  output  16  register read data, combinational from Addr.
- DataWr  input  16  CPU write data; ignored by EOI.
- En  input  1  block chip select, asynchronous.
- Rd  input  1  CPU read strobe, asynchronous.
- Wr  input  1  CPU write strobe, asynchronous.
- IntStatus  input  16  masked pending lines, level, one per source.
- IntReset  output  16  one-hot clear pulse to sources.
- IntReq  output  1  CPU interrupt request, registered.
- Vector  output  4  index of the current granted source.
- VectorValid  output  1  high in states PEND and SERVICE.

## Operation
Bus front end:
- Addr, En, Rd and Wr each pass through one Clk register (AddrSync, EnSync, RdSync, WrSync).
- RdPos = rising edge of RdSync; WrPos = rising edge of WrSync. Both are qualified by EnSync.

Registers:
- Addr 0, read: bit15 = VectorValid, bits3:0 = Vector, all other bits 0. A RdPos at addr 0 while in PEND is the claim.
- Addr 1, read: one-hot in-service mask; nonzero only in SERVICE.
- Addr 1, write: EOI.
- Addr 2, read: raw IntStatus.
- Other addresses read as 16'h0000. Writes to any address other than 1 are ignored.

State machine: IDLE, PEND, SERVICE, CLEAR, HOLD.
- IDLE: when IntStatus != 0, latch the arbitration winner into Vector and go to PEND.
- PEND: IntReq = 1. A claim moves to SERVICE. If IntStatus[Vector] = 0 with no claim in the same cycle (withdrawn source), return to IDLE.
- SERVICE: IntReq = 0. An EOI write moves to CLEAR. IntStatus changes are ignored here.
- CLEAR: IntReset = one-hot(Vector) for exactly this cycle. Always go to HOLD.
- HOLD: a one-cycle guard so the cleared source's stale level is not re-taken. Always go to IDLE.

Arbitration:
- Fixed priority: the lowest set index wins.
- Round-robin, when compiled in: see Configuration.

Boundary conditions:
- Claim and withdrawal in the same cycle: the claim wins.
- EOI outside SERVICE: ignored, no IntReset.
- Claim outside PEND: the read returns data but has no effect.
- Reset in any state, including CLEAR: next state IDLE and IntReset = 0 on the following edge.

## Timing
Reset values:
- State IDLE, IntReq 0, Vector 0, VectorValid 0, IntReset 0, round-robin pointer 0.
- All sync registers 0.

Latencies:
- IntStatus change to IntReq high: 2 Clk (one edge into PEND, one edge into the registered IntReq).
- Bus strobe edge to detection: 2 Clk (sync register plus edge register). The state change follows on the next edge.
- EOI WrPos to IntReset pulse: 1 Clk. Pulse width is exactly 1 Clk.
- IntReset pulse to earliest next PEND: 2 Clk (through HOLD, then IDLE).
- DataRd has no Clk latency; it is combinational from Addr and the current state.

## Configuration
- INTSCHED_ROUNDROBIN_EN defined:
  - Arbitration searches upward from a pointer, wrapping from 15 to 0.
  - In CLEAR the pointer becomes (Vector + 1) mod 16.
- INTSCHED_ROUNDROBIN_EN undefined:
  - Fixed lowest-index priority.
  - The pointer register is not implemented.

## Test plan
- Reset, then IntStatus = 16'h0000: IntReq 0, DataRd at addr 0 = 16'h0000, IntReset 0.
- IntStatus = 16'h0028:
  - IntReq rises 2 Clk later; addr 0 reads 16'h8003.
  - Claim read: IntReq falls; addr 1 reads 16'h0008.
  - EOI write: IntReset = 16'h0008 for 1 Clk.
- IntStatus = 16'h0010, then source drops to 0 before any claim: returns to IDLE, IntReq 0, no IntReset.
- EOI write in IDLE and a claim read in SERVICE: no state change, IntReset stays 0.
- With INTSCHED_ROUNDROBIN_EN, IntStatus held at 16'h8001 and sources cleared externally: vectors alternate 0, 15, 0. Without the macro, vector 0 is granted every time.
- Reset asserted during CLEAR: IntReset 0 on the next edge, state IDLE, Vector 0.

Source files
------------

// File: rtl/int_vector_sched_if.sv
// -----------------------------------------------------------------------------
// int_vector_sched_if
//
// CPU register-bus bundle for the interrupt vectoring scheduler.
// All CPU-driven signals are asynchronous to the scheduler clock. The
// scheduler resynchronises them internally.
//
// Signals:
//   Addr    [3:0]  CPU register address
//   DataRd  [15:0] register read data (combinational from Addr)
//   DataWr  [15:0] CPU write data
//   En             block chip select
//   Rd             CPU read strobe
//   Wr             CPU write strobe
//
// Modports:
//   master  CPU side   (drives Addr/DataWr/En/Rd/Wr, receives DataRd)
//   slave   block side (receives Addr/DataWr/En/Rd/Wr, drives DataRd)
// -----------------------------------------------------------------------------
interface int_vector_sched_if;
    logic [3:0]  Addr;
    logic [15:0] DataRd;
    logic [15:0] DataWr;
    logic        En;
    logic        Rd;
    logic        Wr;

    modport master (
        output Addr,
        output DataWr,
        output En,
        output Rd,
        output Wr,
        input  DataRd
    );

    modport slave (
        input  Addr,
        input  DataWr,
        input  En,
        input  Rd,
        input  Wr,
        output DataRd
    );
endinterface

// File: rtl/int_vector_sched.sv
// -----------------------------------------------------------------------------
// int_vector_sched
//
// Interrupt vectoring scheduler between the interrupt controller and the CPU.
// It arbitrates among 16 masked pending interrupt lines and presents one
// winning source as a 4-bit vector. The CPU claims the vector by reading
// address 0 and closes it by writing address 1 (EOI). On EOI a one-cycle
// one-hot clear pulse is sent to the source, followed by a one-cycle guard
// before the lines are rescanned.
//
// Ports:
//   Clk          system clock
//   Reset        synchronous, active-high reset
//   cpuBus       register bus (int_vector_sched_if.slave):
//                  Addr/En/Rd/Wr/DataWr in, DataRd out
//   IntStatus    [15:0] masked pending lines, level, one per source
//   IntReset     [15:0] one-hot clear pulse to sources (registered)
//   IntReq       CPU interrupt request (registered)
//   Vector       [3:0]  index of the granted source (registered)
//   VectorValid  high while in PEND or SERVICE (registered)
//
// Register map:
//   0 read : {VectorValid, 11'b0, Vector}; a read here while PEND claims
//   1 read : one-hot in-service mask, nonzero only in SERVICE
//   1 write: EOI
//   2 read : raw IntStatus
//   others : read 16'h0000, writes ignored
//
// Build option:
//   INTSCHED_ROUNDROBIN_EN  when defined, arbitration searches upward from a
//                           rotating pointer (wrapping 15 -> 0) and the
//                           pointer moves past each source as it is cleared.
//                           When undefined, the lowest set index wins and no
//                           pointer register exists.
// -----------------------------------------------------------------------------
module int_vector_sched (
    input  logic                     Clk,
    input  logic                     Reset,
    int_vector_sched_if.slave        cpuBus,
    input  logic [15:0]              IntStatus,
    output logic [15:0]              IntReset,
    output logic                     IntReq,
    output logic [3:0]               Vector,
    output logic                     VectorValid
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PEND    = 3'd1,
        SERVICE = 3'd2,
        CLEAR   = 3'd3,
        HOLD    = 3'd4
    } state_t;

    state_t      state;

    // Bus front end: one synchronising stage, then a registered edge detect.
    logic [3:0]  AddrSync;
    logic        EnSync;
    logic        RdSync;
    logic        WrSync;
    logic        RdPrev;
    logic        WrPrev;
    logic        RdPos;
    logic        WrPos;
    logic [3:0]  PosAddr;

    logic        claim;
    logic        eoi;
    logic [3:0]  winner;

    // EOI carries no payload, so the write data is intentionally unused.
    logic        unusedDataWr;
    assign unusedDataWr = ^cpuBus.DataWr;

    // Decode a 4-bit index into a 16-bit one-hot mask.
    function automatic logic [15:0] oneHot(input logic [3:0] idx);
        return 16'h0001 << idx;
    endfunction

    // Lowest set index wins; an all-zero request returns 0 (never used).
    function automatic logic [3:0] pickFixed(input logic [15:0] req);
        logic [3:0] win;
        win = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (req[i]) begin
                win = 4'(i);
            end else begin
                win = win;
            end
        end
        return win;
    endfunction

`ifdef INTSCHED_ROUNDROBIN_EN
    logic [3:0]  RrPtr;

    // First set index at or above ptr, wrapping from 15 back to 0. Scanning
    // the offsets downward lets the smallest offset overwrite the result.
    function automatic logic [3:0] pickRoundRobin(input logic [15:0] req,
                                                  input logic [3:0]  ptr);
        logic [3:0] win;
        logic [3:0] idx;
        win = ptr;
        for (int k = 15; k >= 0; k--) begin
            idx = ptr + 4'(k);
            if (req[idx]) begin
                win = idx;
            end else begin
                win = win;
            end
        end
        return win;
    endfunction

    assign winner = pickRoundRobin(IntStatus, RrPtr);
`else
    assign winner = pickFixed(IntStatus);
`endif

    // Strobe events are only acted on at the address captured with the edge,
    // so the address cannot slip between detection and use.
    assign claim = RdPos && (PosAddr == 4'd0);
    assign eoi   = WrPos && (PosAddr == 4'd1);

    // Resynchronise the asynchronous bus inputs and detect strobe rising edges.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            AddrSync <= 4'd0;
            EnSync   <= 1'b0;
            RdSync   <= 1'b0;
            WrSync   <= 1'b0;
            RdPrev   <= 1'b0;
            WrPrev   <= 1'b0;
            RdPos    <= 1'b0;
            WrPos    <= 1'b0;
            PosAddr  <= 4'd0;
        end else begin
            AddrSync <= cpuBus.Addr;
            EnSync   <= cpuBus.En;
            RdSync   <= cpuBus.Rd;
            WrSync   <= cpuBus.Wr;
            RdPrev   <= RdSync;
            WrPrev   <= WrSync;
            RdPos    <= EnSync & RdSync & ~RdPrev;
            WrPos    <= EnSync & WrSync & ~WrPrev;
            PosAddr  <= AddrSync;
        end
    end

    // Scheduler state machine with its registered outputs.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= IDLE;
            IntReq      <= 1'b0;
            Vector      <= 4'd0;
            VectorValid <= 1'b0;
            IntReset    <= 16'h0000;
`ifdef INTSCHED_ROUNDROBIN_EN
            RrPtr       <= 4'd0;
`endif
        end else begin
            // IntReq trails entry into PEND by one edge and drops one edge
            // after leaving it.
            IntReq   <= (state == PEND);
            IntReset <= 16'h0000;

            case (state)
                IDLE: begin
                    if (IntStatus != 16'h0000) begin
                        Vector      <= winner;
                        VectorValid <= 1'b1;
                        state       <= PEND;
                    end else begin
                        state       <= IDLE;
                    end
                end

                PEND: begin
                    // A claim beats a withdrawal seen in the same cycle.
                    if (claim) begin
                        state       <= SERVICE;
                    end else if (!IntStatus[Vector]) begin
                        VectorValid <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        state       <= PEND;
                    end
                end

                SERVICE: begin
                    // Source levels are deliberately ignored while in service.
                    if (eoi) begin
                        IntReset    <= oneHot(Vector);
                        VectorValid <= 1'b0;
                        state       <= CLEAR;
                    end else begin
                        state       <= SERVICE;
                    end
                end

                CLEAR: begin
`ifdef INTSCHED_ROUNDROBIN_EN
                    RrPtr <= Vector + 4'd1;
`endif
                    state <= HOLD;
                end

                HOLD: begin
                    // Gives the cleared source a cycle to drop its level.
                    state <= IDLE;
                end

                default: begin
                    VectorValid <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

    // Register read mux, combinational from the raw address.
    always_comb begin
        cpuBus.DataRd = 16'h0000;
        case (cpuBus.Addr)
            4'd0: begin
                cpuBus.DataRd = {VectorValid, 11'd0, Vector};
            end
            4'd1: begin
                if (state == SERVICE) begin
                    cpuBus.DataRd = oneHot(Vector);
                end else begin
                    cpuBus.DataRd = 16'h0000;
                end
            end
            4'd2: begin
                cpuBus.DataRd = IntStatus;
            end
            default: begin
                cpuBus.DataRd = 16'h0000;
            end
        endcase
    end

endmodule
